aurora_bist_checker: RTL
========================

// Module: aurora_bist_checker
// PURPOSE
//   Receive-side PRBS checker for Aurora link BIST; pairs with the MAC's PRBS generator at the far end.
//   Sits on the PHY RX stream (phy_clk domain) after the Aurora PCS/PMA. Self-synchronises to the
//   incoming 64-bit PRBS word sequence, declares lock, then counts sample words and word errors.
// PARAMETERS
//   LOCK_COUNT  16  consecutive correct predictions in SEARCH required to enter LOCKED (>=1)
//   LOSS_COUNT  8   consecutive mispredictions in LOCKED that force return to SEARCH (>=1)
//   CNT_W       48  width of the sample and error counters
// PORTS
//   clk          in   1      PHY user clock; single clock domain
//   rst          in   1      synchronous, active-high reset
//   en           in   1      checker enable (bist_checker_en)
//   channel_up   in   1      Aurora channel status; low forces SEARCH
//   i_tdata      in   64     RX word from PHY
//   i_tvalid     in   1      RX word valid (no backpressure; PHY RX has no tready)
//   locked       out  1      high while in LOCKED
//   samps        out  CNT_W  words received while LOCKED
//   errors       out  CNT_W  mispredicted words received while LOCKED
// BEHAVIOUR
//   PRBS step f(w) = {w[62:0], w[63]^w[62]^w[60]^w[59]}; generator emits w[n+1]=f(w[n]) per valid beat.
//   A beat is the cycle where i_tvalid=1; i_tvalid=0 cycles are ignored (rate gaps), state holds.
//   Reset: state=IDLE, locked=0, samps=0, errors=0, pred=0, match_cnt=0, miss_cnt=0.
//   States:
//   - IDLE: en=0. Counters hold last values (readable after test). en 0->1 edge: samps/errors
//     clear to 0, go SEARCH, match_cnt=0, seed pending.
//   - SEARCH: each beat: if seeded and i_tdata==pred and i_tdata!=0, match_cnt++ else match_cnt=0;
//     always pred<=f(i_tdata). First beat after entry only seeds (never a match).
//     When the beat produces the LOCK_COUNT-th consecutive match: go LOCKED, miss_cnt=0.
//   - LOCKED: pred free-runs, pred<=f(pred) each beat (no resync; one flipped word = one error).
//     Each beat: samps++; if i_tdata!=pred: errors++, miss_cnt++ else miss_cnt=0.
//     miss_cnt reaching LOSS_COUNT: go SEARCH, match_cnt=0, pred<=f(i_tdata) (re-seeded).
//   en=0 in any state -> IDLE next cycle (priority over all transitions except rst).
//   channel_up=0 while en=1 -> SEARCH, match_cnt=0, seed pending; counters hold (not cleared).
//   All-zero word is the LFSR lock-up state: never counts as a match in SEARCH.
//   Outputs registered: locked rises the cycle after the locking beat; the locking beat is not
//   counted in samps. samps/errors update one cycle after the beat.
//   Counters saturate at 2^CNT_W-1 (no wrap); errors saturates independently of samps.
//   rst mid-operation: immediate return to reset values next edge, regardless of en.
// TESTING
//   1 Seed 64'h1, LOCK_COUNT=16, continuous PRBS beats -> locked=1 one cycle after 17th beat;
//     after 256 more beats samps=256, errors=0.
//   2 Locked, flip bit 5 on one word -> errors=1, locked stays 1, subsequent words match (no cascade).
//   3 Locked, send 8 consecutive random non-PRBS words -> errors=8, locked=0 next cycle;
//     resume PRBS -> relock after 17 beats, samps/errors continue from 256+8 / 8.
//   4 Rate gaps: i_tvalid 1-of-4 cycles over 400 cycles post-lock -> samps=100, errors=0.
//   5 Stream of 64'h0 words -> never locks; en deassert then reassert -> samps=errors=0.
//   6 channel_up low 3 cycles while locked -> locked=0, counters held; rst mid-test -> all zero.

Source files
------------

// File: rtl/aurora_bist_checker.sv
// Receive-side PRBS checker for Aurora link BIST: self-synchronises to a 64-bit
// PRBS word stream, declares lock, then counts sample words and word errors.
module aurora_bist_checker #(
   parameter int unsigned LOCK_COUNT = 16,
   parameter int unsigned LOSS_COUNT = 8,
   parameter int unsigned CNT_W      = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             channel_up,
   input  logic [63:0]      i_tdata,
   input  logic             i_tvalid,
   output logic             locked,
   output logic [CNT_W-1:0] samps,
   output logic [CNT_W-1:0] errors
);

   localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_LOCKED} state_t;

   function automatic logic [63:0] prbs_step(input logic [63:0] w);
      return {w[62:0], w[63] ^ w[62] ^ w[60] ^ w[59]};
   endfunction

   state_t           state_q;
   logic             locked_q;
   logic             seeded_q;
   logic [63:0]      pred_q;
   logic [MW-1:0]    match_cnt_q;
   logic [LW-1:0]    miss_cnt_q;
   logic [CNT_W-1:0] samps_q;
   logic [CNT_W-1:0] errors_q;

   logic             pred_hit_d;
   logic             match_d;
   logic [CNT_W-1:0] samps_d;
   logic [CNT_W-1:0] errors_d;

   assign pred_hit_d = (i_tdata == pred_q);
   // The all-zero word is the LFSR lock-up state and must never advance lock.
   assign match_d    = seeded_q && pred_hit_d && (i_tdata != '0);
   assign samps_d    = (samps_q  == '1) ? samps_q  : samps_q  + 1'b1;
   assign errors_d   = (errors_q == '1) ? errors_q : errors_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         locked_q    <= 1'b0;
         seeded_q    <= 1'b0;
         pred_q      <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         samps_q     <= '0;
         errors_q    <= '0;
      end else if (!en) begin
         state_q  <= S_IDLE;
         locked_q <= 1'b0;
      end else if (state_q == S_IDLE) begin
         // Only reachable with en high right after it was low: start a new run.
         state_q     <= S_SEARCH;
         locked_q    <= 1'b0;
         seeded_q    <= 1'b0;
         match_cnt_q <= '0;
         samps_q     <= '0;
         errors_q    <= '0;
      end else if (!channel_up) begin
         state_q     <= S_SEARCH;
         locked_q    <= 1'b0;
         seeded_q    <= 1'b0;
         match_cnt_q <= '0;
      end else if (i_tvalid) begin
         case (state_q)
            S_SEARCH: begin
               pred_q   <= prbs_step(i_tdata);
               seeded_q <= 1'b1;
               if (match_d) begin
                  match_cnt_q <= match_cnt_q + 1'b1;
                  if (match_cnt_q == MW'(LOCK_COUNT - 1)) begin
                     state_q    <= S_LOCKED;
                     locked_q   <= 1'b1;
                     miss_cnt_q <= '0;
                  end
               end else begin
                  match_cnt_q <= '0;
               end
            end
            S_LOCKED: begin
               // Free-running prediction: a single corrupted word costs one error.
               pred_q  <= prbs_step(pred_q);
               samps_q <= samps_d;
               if (!pred_hit_d) begin
                  errors_q   <= errors_d;
                  miss_cnt_q <= miss_cnt_q + 1'b1;
                  if (miss_cnt_q == LW'(LOSS_COUNT - 1)) begin
                     state_q     <= S_SEARCH;
                     locked_q    <= 1'b0;
                     match_cnt_q <= '0;
                     seeded_q    <= 1'b1;
                     pred_q      <= prbs_step(i_tdata);
                  end
               end else begin
                  miss_cnt_q <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign locked = locked_q;
   assign samps  = samps_q;
   assign errors = errors_q;

endmodule
